commit_monitor: RTL and testbench
=================================

Name: commit_monitor

Overview:
- Receiving end of the CPU commit interface.
- Gates the CPU's `global_en` and captures every committed instruction record into a FIFO, which a debug host reads with a valid/ready handshake.
- Counts run cycles and retired instructions, and detects halt and timeout.
- Sits between the CPU top and the debug/simulation harness.

Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥4.
- MAX_CYCLES, 0, RUN-cycle timeout limit; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  host pulse: begin a run (sampled in IDLE/DONE only)
- commit  in  1  CPU commit valid
- commit_pc  in  32  committed PC
- commit_inst  in  32  committed instruction
- commit_halt  in  1  committed instruction is halt
- commit_reg_we  in  1  register write enable of commit
- commit_reg_wa  in  5  register write address
- commit_reg_wd  in  32  register write data
- global_en  out  1  CPU execute enable
- rec_valid  out  1  FIFO head valid
- rec_ready  in  1  host accepts head record
- rec_pc  out  32  head record field
- rec_inst  out  32  head record field
- rec_reg_we  out  1  head record field
- rec_reg_wa  out  5  head record field
- rec_reg_wd  out  32  head record field
- state  out  2  IDLE=0, RUN=1, DRAIN=2, DONE=3
- inst_cnt  out  32  accepted commits in current run
- cycle_cnt  out  32  cycles spent in RUN
- halted  out  1  sticky: run ended by halt
- timeout  out  1  sticky: run ended by MAX_CYCLES
- overflow  out  1  sticky: commit arrived with FIFO full

Behaviour:
- Reset (async, active-high):
  - state=IDLE; FIFO emptied; global_en=0; rec_valid=0; all rec_* fields 0.
  - inst_cnt=0, cycle_cnt=0; halted=0, timeout=0, overflow=0.
  - Reset asserted mid-run takes effect immediately; records in flight are lost.
- FSM:
  - IDLE --start--> RUN. Entering RUN clears inst_cnt, cycle_cnt, halted, timeout and overflow.
  - RUN --accepted commit with commit_halt=1--> DRAIN; set halted.
  - RUN --cycle_cnt reaches MAX_CYCLES (MAX_CYCLES≠0)--> DRAIN; set timeout.
  - If halt and timeout occur in the same cycle, both flags set; go to DRAIN.
  - DRAIN --FIFO empty--> DONE. Evaluated on the count after that cycle's pop.
  - DONE --start--> RUN, with the same clearing as from IDLE.
  - start in RUN or DRAIN is ignored.
- global_en:
  - Combinational: global_en = (state==RUN) && (fifo_count ≤ DEPTH-2).
  - The CPU registers its commit one cycle after enable, so this two-slot margin guarantees no write is ever attempted when full.
- Commit acceptance:
  - A commit is accepted when commit=1, state==RUN and the FIFO is not full.
  - On acceptance: push {pc, inst, reg_we, reg_wa, reg_wd} and increment inst_cnt. The halt commit itself is pushed and counted.
  - Commits arriving in IDLE, DRAIN or DONE are discarded silently and not counted. This covers the one post-halt commit the CPU may produce.
  - commit=1 in RUN with the FIFO full: record dropped, overflow set.
- cycle_cnt:
  - Increments every cycle that state==RUN.
  - Saturates at 32'hFFFF_FFFF.
- FIFO:
  - First-word fall-through; rec_valid = !empty; rec_* show the head entry.
  - Pop on rec_valid && rec_ready.
  - An accepted commit at edge N is visible on rec_* in the cycle after edge N if the FIFO was empty.
  - Push and pop in the same cycle: count unchanged; legal at full and at empty. At empty the new record appears next cycle.
  - Pointers wrap modulo DEPTH. Count width is log2(DEPTH)+1.
  - rec_* hold their value while !rec_ready (stable under backpressure).
- The FIFO is not cleared on start; it is necessarily empty in DONE/IDLE.

Test Plan:
- Reset during RUN with 3 records queued → all outputs return to reset values asynchronously; global_en=0, rec_valid=0, state=0.
- start, rec_ready=1, CPU commits pc=0,4,8 (commit_halt=0) → records appear in order, each one cycle after its commit; inst_cnt=3; global_en stays 1.
- DEPTH=8, rec_ready=0, commit every cycle → global_en falls in the cycle fifo_count=7; count peaks at 8; overflow=0. Raising rec_ready drains pc order intact and global_en reasserts at count≤6.
- Halt commit (inst=32'h8000_0000) at pc=0x10, plus one extra commit the next cycle → halt record queued; extra commit discarded; inst_cnt counts up to and including the halt; state goes DRAIN then DONE after the last pop; halted=1.
- MAX_CYCLES=5, no halt → after 5 RUN cycles state=DRAIN, timeout=1, cycle_cnt=5, global_en=0. A subsequent start from DONE clears the counters and flags.
- Force commit=1 in RUN with the FIFO full (bench-driven) → overflow=1 (sticky), FIFO contents unchanged, inst_cnt unchanged.

Source files
------------

// File: rtl/commit_monitor.sv
// Commit-interface receiver: gates global_en, queues commit records in a FWFT FIFO for the host, tracks run/halt/timeout.
// Record visible one cycle after acceptance; host backpressure via rec_ready, CPU throttled by global_en two slots before full.
module commit_monitor #(
    parameter int          DEPTH      = 8,
    parameter int unsigned MAX_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        commit,
    input  logic [31:0] commit_pc,
    input  logic [31:0] commit_inst,
    input  logic        commit_halt,
    input  logic        commit_reg_we,
    input  logic [4:0]  commit_reg_wa,
    input  logic [31:0] commit_reg_wd,
    output logic        global_en,
    output logic        rec_valid,
    input  logic        rec_ready,
    output logic [31:0] rec_pc,
    output logic [31:0] rec_inst,
    output logic        rec_reg_we,
    output logic [4:0]  rec_reg_wa,
    output logic [31:0] rec_reg_wd,
    output logic [1:0]  state,
    output logic [31:0] inst_cnt,
    output logic [31:0] cycle_cnt,
    output logic        halted,
    output logic        timeout,
    output logic        overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = 32 + 32 + 1 + 5 + 32;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam logic [AW:0] FULL_CNT  = (AW + 1)'(DEPTH);
    localparam logic [AW:0] EN_LIMIT  = (AW + 1)'(DEPTH - 2);
    localparam logic [31:0] MAX_LIMIT = MAX_CYCLES[31:0];

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [RW-1:0] mem_q [DEPTH];
    logic [31:0]   inst_cnt_q, inst_cnt_d, cycle_cnt_q, cycle_cnt_d;
    logic          halted_q, halted_d, timeout_q, timeout_d, overflow_q, overflow_d;

    logic          full, empty, push, pop, timeout_hit, halt_hit;
    logic [31:0]   cyc_inc;
    logic [RW-1:0] push_dat, head_dat;

    always_comb begin
        full        = (count_q == FULL_CNT);
        empty       = (count_q == '0);
        push        = commit && (state_q == S_RUN) && !full;
        pop         = !empty && rec_ready;
        push_dat    = {commit_pc, commit_inst, commit_reg_we, commit_reg_wa, commit_reg_wd};
        cyc_inc     = (cycle_cnt_q == 32'hFFFF_FFFF) ? cycle_cnt_q : cycle_cnt_q + 32'd1;
        timeout_hit = (MAX_LIMIT != 32'd0) && (cyc_inc == MAX_LIMIT);
        halt_hit    = push && commit_halt;

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        state_d     = state_q;
        inst_cnt_d  = inst_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        halted_d    = halted_q;
        timeout_d   = timeout_q;
        overflow_d  = overflow_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_RUN;
                    inst_cnt_d  = '0;
                    cycle_cnt_d = '0;
                    halted_d    = 1'b0;
                    timeout_d   = 1'b0;
                    overflow_d  = 1'b0;
                end
            end
            S_RUN: begin
                cycle_cnt_d = cyc_inc;
                if (push) inst_cnt_d = inst_cnt_q + 32'd1;
                if (commit && full) overflow_d = 1'b1;
                if (halt_hit) halted_d = 1'b1;
                if (timeout_hit) timeout_d = 1'b1;
                if (halt_hit || timeout_hit) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // Post-pop occupancy, so the last pop and the exit happen on the same edge
                if (count_d == '0) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            inst_cnt_q  <= '0;
            cycle_cnt_q <= '0;
            halted_q    <= 1'b0;
            timeout_q   <= 1'b0;
            overflow_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            inst_cnt_q  <= inst_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            halted_q    <= halted_d;
            timeout_q   <= timeout_d;
            overflow_q  <= overflow_d;
            if (push) mem_q[wr_ptr_q] <= push_dat;
        end
    end

    // Two free slots cover the commit the CPU may already have in flight
    assign global_en  = (state_q == S_RUN) && (count_q <= EN_LIMIT);
    assign head_dat   = mem_q[rd_ptr_q];
    assign rec_valid  = !empty;
    assign rec_pc     = head_dat[101:70];
    assign rec_inst   = head_dat[69:38];
    assign rec_reg_we = head_dat[37];
    assign rec_reg_wa = head_dat[36:32];
    assign rec_reg_wd = head_dat[31:0];
    assign state      = state_q;
    assign inst_cnt   = inst_cnt_q;
    assign cycle_cnt  = cycle_cnt_q;
    assign halted     = halted_q;
    assign timeout    = timeout_q;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_commit_monitor.sv
// Directed bench for commit_monitor: vector table for the basic run/halt flow, hand sequences for backpressure, overflow, reset and timeout.
module tb_commit_monitor;
    logic        clk = 1'b0;
    logic        rst, start, commit, commit_halt, commit_reg_we, rec_ready;
    logic [31:0] commit_pc, commit_inst, commit_reg_wd;
    logic [4:0]  commit_reg_wa;
    logic        global_en, rec_valid, rec_reg_we, halted, timeout, overflow;
    logic [31:0] rec_pc, rec_inst, rec_reg_wd, inst_cnt, cycle_cnt;
    logic [4:0]  rec_reg_wa;
    logic [1:0]  state;

    logic        start2, commit2, halt2;
    logic        global_en2, rec_valid2, rec_reg_we2, halted2, timeout2, overflow2;
    logic [31:0] rec_pc2, rec_inst2, rec_reg_wd2, inst_cnt2, cycle_cnt2;
    logic [4:0]  rec_reg_wa2;
    logic [1:0]  state2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    commit_monitor #(.DEPTH(8), .MAX_CYCLES(0)) dut (
        .clk(clk), .rst(rst), .start(start), .commit(commit), .commit_pc(commit_pc),
        .commit_inst(commit_inst), .commit_halt(commit_halt), .commit_reg_we(commit_reg_we),
        .commit_reg_wa(commit_reg_wa), .commit_reg_wd(commit_reg_wd), .global_en(global_en),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_pc(rec_pc), .rec_inst(rec_inst),
        .rec_reg_we(rec_reg_we), .rec_reg_wa(rec_reg_wa), .rec_reg_wd(rec_reg_wd), .state(state),
        .inst_cnt(inst_cnt), .cycle_cnt(cycle_cnt), .halted(halted), .timeout(timeout),
        .overflow(overflow)
    );

    commit_monitor #(.DEPTH(8), .MAX_CYCLES(5)) dut_t (
        .clk(clk), .rst(rst), .start(start2), .commit(commit2), .commit_pc(commit_pc),
        .commit_inst(commit_inst), .commit_halt(halt2), .commit_reg_we(commit_reg_we),
        .commit_reg_wa(commit_reg_wa), .commit_reg_wd(commit_reg_wd), .global_en(global_en2),
        .rec_valid(rec_valid2), .rec_ready(rec_ready), .rec_pc(rec_pc2), .rec_inst(rec_inst2),
        .rec_reg_we(rec_reg_we2), .rec_reg_wa(rec_reg_wa2), .rec_reg_wd(rec_reg_wd2), .state(state2),
        .inst_cnt(inst_cnt2), .cycle_cnt(cycle_cnt2), .halted(halted2), .timeout(timeout2),
        .overflow(overflow2)
    );

    typedef struct {
        logic        st;
        logic        cm;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        hlt;
        logic        rdy;
        logic [1:0]  e_state;
        logic        e_en;
        logic        e_vld;
        logic        chk_rec;
        logic [31:0] e_pc;
        logic [31:0] e_icnt;
        logic [31:0] e_ccnt;
        logic        e_halted;
    } vec_t;

    vec_t        tbl [9];
    logic [31:0] exp_pc [$];
    logic [31:0] exp_wd [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_commit(input logic [31:0] n);
        commit_pc     = 32'h100 + (n << 2);
        commit_inst   = 32'h0010_0093 + n;
        commit_reg_we = 1'b1;
        commit_reg_wa = n[4:0] + 5'd1;
        commit_reg_wd = 32'hA5A5_0000 | n;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   exp_cnt;
        int   npush;
        logic prev_en;

        rst = 1'b1; start = 1'b0; commit = 1'b0; commit_halt = 1'b0; rec_ready = 1'b0;
        commit_pc = '0; commit_inst = '0; commit_reg_we = 1'b0; commit_reg_wa = '0; commit_reg_wd = '0;
        start2 = 1'b0; commit2 = 1'b0; halt2 = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        tick();
        check("reset_state", 32'(state), 32'd0);
        check("reset_en", 32'(global_en), 32'd0);
        check("reset_vld", 32'(rec_valid), 32'd0);
        check("reset_flags", 32'({halted, timeout, overflow}), 32'd0);
        check("reset_cnts", inst_cnt | cycle_cnt, 32'd0);

        //             st    cm    pc           inst           hlt   rdy   state en    vld   chk   e_pc      icnt   ccnt   halted
        tbl[0] = '{1'b1, 1'b0, 32'h0,  32'h13,        1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 32'h0,  32'd0, 32'd0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 32'h0,  32'h13,        1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 32'h0,  32'd1, 32'd1, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 32'h4,  32'h13,        1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 32'h4,  32'd2, 32'd2, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 32'h8,  32'h13,        1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 32'h8,  32'd3, 32'd3, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 32'h0,  32'h13,        1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 32'h0,  32'd3, 32'd4, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 32'h10, 32'h8000_0000, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b1, 32'h10, 32'd4, 32'd5, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 32'h14, 32'h13,        1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 1'b1, 32'h10, 32'd4, 32'd5, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 32'h0,  32'h13,        1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 32'h0,  32'd4, 32'd5, 1'b1};
        tbl[8] = '{1'b1, 1'b0, 32'h0,  32'h13,        1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 32'h0,  32'd0, 32'd0, 1'b0};

        for (int i = 0; i < 9; i++) begin
            start = tbl[i].st; commit = tbl[i].cm; commit_pc = tbl[i].pc;
            commit_inst = tbl[i].inst; commit_halt = tbl[i].hlt; rec_ready = tbl[i].rdy;
            tick();
            check($sformatf("v%0d_state", i), 32'(state), 32'(tbl[i].e_state));
            check($sformatf("v%0d_en", i), 32'(global_en), 32'(tbl[i].e_en));
            check($sformatf("v%0d_vld", i), 32'(rec_valid), 32'(tbl[i].e_vld));
            if (tbl[i].chk_rec) check($sformatf("v%0d_pc", i), rec_pc, tbl[i].e_pc);
            check($sformatf("v%0d_icnt", i), inst_cnt, tbl[i].e_icnt);
            check($sformatf("v%0d_ccnt", i), cycle_cnt, tbl[i].e_ccnt);
            check($sformatf("v%0d_halted", i), 32'(halted), 32'(tbl[i].e_halted));
        end
        start = 1'b0; commit = 1'b0; commit_halt = 1'b0;

        // Backpressure: CPU model commits one cycle after each enabled cycle
        rec_ready = 1'b0; exp_cnt = 0; prev_en = 1'b0; npush = 0;
        for (int k = 0; k < 10; k++) begin
            check($sformatf("bp%0d_en", k), 32'(global_en), (exp_cnt <= 6) ? 32'd1 : 32'd0);
            commit = prev_en;
            if (prev_en) begin
                drive_commit(32'(npush));
                exp_pc.push_back(commit_pc);
                exp_wd.push_back(commit_reg_wd);
                npush++;
            end
            prev_en = (exp_cnt <= 6);
            tick();
            if (commit) exp_cnt++;
        end
        commit = 1'b0;
        check("bp_peak_cnt", 32'(exp_cnt), 32'd8);
        check("bp_overflow", 32'(overflow), 32'd0);
        check("bp_icnt", inst_cnt, 32'd8);
        rec_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            check($sformatf("dr%0d_vld", j), 32'(rec_valid), 32'd1);
            check($sformatf("dr%0d_pc", j), rec_pc, exp_pc.pop_front());
            check($sformatf("dr%0d_wd", j), rec_reg_wd, exp_wd.pop_front());
            check($sformatf("dr%0d_en", j), 32'(global_en), ((8 - j) <= 6) ? 32'd1 : 32'd0);
            tick();
        end
        check("dr_empty", 32'(rec_valid), 32'd0);
        check("dr_en", 32'(global_en), 32'd1);

        // Overflow: bench ignores global_en and forces a commit at full
        rec_ready = 1'b0;
        for (int j = 0; j < 8; j++) begin
            commit = 1'b1; commit_pc = 32'h200 + 32'(j) * 4;
            tick();
        end
        check("ov_pre_icnt", inst_cnt, 32'd16);
        check("ov_pre_flag", 32'(overflow), 32'd0);
        commit_pc = 32'hDEAD_0000;
        tick();
        commit = 1'b0;
        check("ov_flag", 32'(overflow), 32'd1);
        check("ov_icnt", inst_cnt, 32'd16);
        check("ov_head", rec_pc, 32'h200);
        tick();
        check("ov_sticky", 32'(overflow), 32'd1);
        rec_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            check($sformatf("ov_dr%0d_pc", j), rec_pc, 32'h200 + 32'(j) * 4);
            tick();
        end
        check("ov_dr_empty", 32'(rec_valid), 32'd0);

        // Asynchronous reset mid-run with three records queued
        rec_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            commit = 1'b1; drive_commit(32'h40 + 32'(j));
            tick();
        end
        commit = 1'b0;
        check("rst_pre_vld", 32'(rec_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_state", 32'(state), 32'd0);
        check("arst_en", 32'(global_en), 32'd0);
        check("arst_vld", 32'(rec_valid), 32'd0);
        check("arst_rec", rec_pc | rec_inst | rec_reg_wd | 32'(rec_reg_wa) | 32'(rec_reg_we), 32'd0);
        check("arst_cnts", inst_cnt | cycle_cnt, 32'd0);
        check("arst_flags", 32'({halted, timeout, overflow}), 32'd0);
        tick();
        #3 rst = 1'b0;
        tick();
        check("arst_after_vld", 32'(rec_valid), 32'd0);

        // Timeout instance: MAX_CYCLES=5
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        check("to_run", 32'(state2), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("to_c%0d", k), cycle_cnt2, 32'(k));
        end
        check("to_still_run", 32'(state2), 32'd1);
        tick();
        check("to_state", 32'(state2), 32'd2);
        check("to_flag", 32'(timeout2), 32'd1);
        check("to_cyc", cycle_cnt2, 32'd5);
        check("to_en", 32'(global_en2), 32'd0);
        tick();
        check("to_done", 32'(state2), 32'd3);
        check("to_done_cyc", cycle_cnt2, 32'd5);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        check("to_rst_state", 32'(state2), 32'd1);
        check("to_rst_cyc", cycle_cnt2, 32'd0);
        check("to_rst_flags", 32'({halted2, timeout2, overflow2}), 32'd0);
        repeat (4) tick();
        commit2 = 1'b1; halt2 = 1'b1; drive_commit(32'h77); rec_ready = 1'b0;
        tick();
        commit2 = 1'b0; halt2 = 1'b0;
        check("both_state", 32'(state2), 32'd2);
        check("both_halted", 32'(halted2), 32'd1);
        check("both_timeout", 32'(timeout2), 32'd1);
        check("both_icnt", inst_cnt2, 32'd1);
        check("both_vld", 32'(rec_valid2), 32'd1);
        check("both_pc", rec_pc2, 32'h100 + (32'h77 << 2));
        check("both_inst", rec_inst2, 32'h0010_0093 + 32'h77);
        check("both_we_wa", 32'({rec_reg_we2, rec_reg_wa2}), 32'({1'b1, 5'h18}));
        check("both_wd", rec_reg_wd2, 32'hA5A5_0077);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
